// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between the core MEM stage
// and the NoC network-interface block-transfer engine. One access is outstanding at a time.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    // core MEM stage
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_stall,
    // network interface
    input  logic              ni_req,
    input  logic              ni_we,
    input  logic [ADDR_W-1:0] ni_addr,
    input  logic [DATA_W-1:0] ni_wdata,
    output logic [DATA_W-1:0] ni_rdata,
    output logic              ni_done,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(MEM_LAT) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        OwnCore = 1'b0,
        OwnNi   = 1'b1
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            rr_last_q, rr_last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] ni_rdata_q, ni_rdata_d;
    logic              core_done_q, core_done_d;
    logic              ni_done_q, ni_done_d;

    logic core_req;
    logic turnaround;
    logic grant_ni;

    assign core_req = core_rd | core_wr;

    // Requests are still asserted in the done cycle for the access just finished, so the
    // IDLE cycle that carries a done pulse must not arbitrate.
    assign turnaround = core_done_q | ni_done_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rdata_d = core_rdata_q;
        ni_rdata_d   = ni_rdata_q;
        core_done_d  = 1'b0;
        ni_done_d    = 1'b0;
        grant_ni     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!turnaround && (core_req || ni_req)) begin
                    if (core_req && ni_req) begin
                        grant_ni = (rr_last_q == OwnCore);
                    end else begin
                        grant_ni = ni_req;
                    end
                    owner_d     = grant_ni ? OwnNi : OwnCore;
                    // core rd&wr together counts as a write
                    we_d        = grant_ni ? ni_we : core_wr;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_ni ? ni_we : core_wr;
                    mem_addr_d  = grant_ni ? ni_addr : core_addr;
                    mem_wdata_d = grant_ni ? ni_wdata : core_wdata;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntW'(MEM_LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OwnCore) begin
                            core_rdata_d = mem_rdata;
                        end else begin
                            ni_rdata_d = mem_rdata;
                        end
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                core_done_d = (owner_q == OwnCore);
                ni_done_d   = (owner_q == OwnNi);
                rr_last_d   = owner_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnCore;
            rr_last_q    <= OwnNi;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            ni_rdata_q   <= '0;
            core_done_q  <= 1'b0;
            ni_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rdata_q <= core_rdata_d;
            ni_rdata_q   <= ni_rdata_d;
            core_done_q  <= core_done_d;
            ni_done_q    <= ni_done_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_rdata = core_rdata_q;
    assign ni_rdata   = ni_rdata_q;
    assign core_done  = core_done_q;
    assign ni_done    = ni_done_q;
    assign core_stall = core_req & ~core_done_q;

    // The strobe is a single cycle and only one requester can complete at a time.
    a_mem_en_single : assert property (@(posedge clk) disable iff (rst) mem_en_q |=> !mem_en_q);
    a_done_onehot   : assert property (@(posedge clk) disable iff (rst) !(core_done_q && ni_done_q));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance at MEM_LAT=2 (dut_a) and one at MEM_LAT=1
// (dut_b), each backed by a small memory model that presents data only in its valid cycle.
module tb_dmem_port_arbiter;

    logic clk;
    logic rst;

    logic        a_core_rd, a_core_wr, a_core_done, a_core_stall;
    logic [31:0] a_core_addr, a_core_wdata, a_core_rdata;
    logic        a_ni_req, a_ni_we, a_ni_done;
    logic [31:0] a_ni_addr, a_ni_wdata, a_ni_rdata;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_core_rd, b_core_wr, b_core_done, b_core_stall;
    logic [31:0] b_core_addr, b_core_wdata, b_core_rdata;
    logic        b_ni_req, b_ni_we, b_ni_done;
    logic [31:0] b_ni_addr, b_ni_wdata, b_ni_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_cmp;
    int n_bad;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut_a (
        .clk(clk), .rst(rst),
        .core_rd(a_core_rd), .core_wr(a_core_wr), .core_addr(a_core_addr),
        .core_wdata(a_core_wdata), .core_rdata(a_core_rdata), .core_done(a_core_done),
        .core_stall(a_core_stall),
        .ni_req(a_ni_req), .ni_we(a_ni_we), .ni_addr(a_ni_addr), .ni_wdata(a_ni_wdata),
        .ni_rdata(a_ni_rdata), .ni_done(a_ni_done),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .core_rd(b_core_rd), .core_wr(b_core_wr), .core_addr(b_core_addr),
        .core_wdata(b_core_wdata), .core_rdata(b_core_rdata), .core_done(b_core_done),
        .core_stall(b_core_stall),
        .ni_req(b_ni_req), .ni_we(b_ni_we), .ni_addr(b_ni_addr), .ni_wdata(b_ni_wdata),
        .ni_rdata(b_ni_rdata), .ni_done(b_ni_done),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=2 memory: data is valid only in the second cycle after mem_en.
    logic [31:0] mem_a [0:255];
    logic [31:0] a_pipe;
    logic        a_pipe_v;
    always @(posedge clk) begin
        if (rst) begin
            mem_a[16] <= 32'hDEADBEEF;
            mem_a[17] <= 32'hCAFEF00D;
        end else if (a_mem_en && a_mem_we) begin
            mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
        end
        a_pipe      <= mem_a[a_mem_addr[9:2]];
        a_pipe_v    <= a_mem_en && !a_mem_we;
        a_mem_rdata <= a_pipe_v ? a_pipe : 32'hBAD0BAD0;
    end

    // MEM_LAT=1 memory.
    logic [31:0] mem_b [0:255];
    always @(posedge clk) begin
        if (rst) begin
            mem_b[16] <= 32'h600DCAFE;
        end else if (b_mem_en && b_mem_we) begin
            mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
        end
        b_mem_rdata <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[9:2]] : 32'hBAD0BAD0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit into the new cycle, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int          n_iss;
    logic [31:0] iss_addr [0:4];
    int          iss_cyc  [0:4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        {a_core_rd, a_core_wr, a_ni_req, a_ni_we} = '0;
        {a_core_addr, a_core_wdata, a_ni_addr, a_ni_wdata} = '0;
        {b_core_rd, b_core_wr, b_ni_req, b_ni_we} = '0;
        {b_core_addr, b_core_wdata, b_ni_addr, b_ni_wdata} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst a mem_en", a_mem_en, 0);
        check("rst a mem_we", a_mem_we, 0);
        check("rst a mem_addr", a_mem_addr, 0);
        check("rst a mem_wdata", a_mem_wdata, 0);
        check("rst a core_rdata", a_core_rdata, 0);
        check("rst a ni_rdata", a_ni_rdata, 0);
        check("rst a dones", {a_core_done, a_ni_done}, 0);
        check("rst b outs", {b_mem_en, b_mem_we, b_core_done, b_ni_done}, 0);
        check("rst b rdata", b_core_rdata | b_ni_rdata | b_mem_addr, 0);

        // 1: core read of 0x40
        for (int c = 0; c <= 6; c++) begin
            cyc();
            if (c == 0) begin a_core_rd = 1'b1; a_core_addr = 32'h40; end
            if (c == 6) a_core_rd = 1'b0;
            #1;
            check($sformatf("t1 stall c%0d", c), a_core_stall, c <= 4);
            check($sformatf("t1 mem_en c%0d", c), a_mem_en, c == 1);
            check($sformatf("t1 core_done c%0d", c), a_core_done, c == 5);
            if (c == 1) begin
                check("t1 mem_addr", a_mem_addr, 32'h40);
                check("t1 mem_we", a_mem_we, 0);
            end
            if (c == 5) check("t1 core_rdata", a_core_rdata, 32'hDEADBEEF);
        end

        // 2: reset, then core write and NI read together
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; #1;
        check("t2 rst core_rdata", a_core_rdata, 0);
        for (int c = 0; c <= 12; c++) begin
            cyc();
            if (c == 0) begin
                a_core_wr = 1'b1; a_core_addr = 32'h80; a_core_wdata = 32'hA5A5A5A5;
                a_ni_req = 1'b1; a_ni_we = 1'b0; a_ni_addr = 32'h40;
            end
            if (c == 6) a_core_wr = 1'b0;
            if (c == 12) a_ni_req = 1'b0;
            #1;
            check($sformatf("t2 mem_en c%0d", c), a_mem_en, (c == 1) || (c == 7));
            check($sformatf("t2 core_done c%0d", c), a_core_done, c == 5);
            check($sformatf("t2 ni_done c%0d", c), a_ni_done, c == 11);
            if (c == 1) begin
                check("t2 core we", a_mem_we, 1);
                check("t2 core addr", a_mem_addr, 32'h80);
                check("t2 core wdata", a_mem_wdata, 32'hA5A5A5A5);
            end
            if (c == 7) begin
                check("t2 ni we", a_mem_we, 0);
                check("t2 ni addr", a_mem_addr, 32'h40);
            end
            if (c == 11) check("t2 ni_rdata", a_ni_rdata, 32'hDEADBEEF);
        end
        check("t2 core_rdata after write", a_core_rdata, 0);

        // 3: both requesting continuously
        n_iss = 0;
        for (int c = 0; c <= 31; c++) begin
            cyc();
            if (c == 0) begin
                a_core_rd = 1'b1; a_core_addr = 32'h40;
                a_ni_req = 1'b1; a_ni_we = 1'b0; a_ni_addr = 32'h44;
            end
            if (c == 26) begin a_core_rd = 1'b0; a_ni_req = 1'b0; end
            #1;
            if (a_mem_en) begin
                if (n_iss < 5) begin
                    iss_addr[n_iss] = a_mem_addr;
                    iss_cyc[n_iss]  = c;
                end
                n_iss++;
            end
        end
        check("t3 issue count", n_iss, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < n_iss) begin
                check($sformatf("t3 issue%0d owner", i), iss_addr[i],
                      (i % 2 == 0) ? 32'h40 : 32'h44);
                check($sformatf("t3 issue%0d cycle", i), iss_cyc[i], 1 + 6 * i);
            end
        end
        check("t3 core_rdata", a_core_rdata, 32'hDEADBEEF);
        check("t3 ni_rdata", a_ni_rdata, 32'hCAFEF00D);

        // 4: NI write 0x100, then core read it back
        for (int c = 0; c <= 12; c++) begin
            cyc();
            if (c == 0) begin
                a_ni_req = 1'b1; a_ni_we = 1'b1; a_ni_addr = 32'h100; a_ni_wdata = 32'h12345678;
            end
            if (c == 6) begin
                a_ni_req = 1'b0; a_ni_we = 1'b0;
                a_core_rd = 1'b1; a_core_addr = 32'h100;
            end
            if (c == 12) a_core_rd = 1'b0;
            #1;
            check($sformatf("t4 mem_en c%0d", c), a_mem_en, (c == 1) || (c == 7));
            if (c == 1) begin
                check("t4 ni we", a_mem_we, 1);
                check("t4 ni addr", a_mem_addr, 32'h100);
                check("t4 ni wdata", a_mem_wdata, 32'h12345678);
            end
            if (c == 5) begin
                check("t4 ni_done", a_ni_done, 1);
                check("t4 ni_rdata after write", a_ni_rdata, 32'hCAFEF00D);
            end
            if (c == 7) check("t4 core we", a_mem_we, 0);
            if (c == 11) begin
                check("t4 core_done", a_core_done, 1);
                check("t4 core_rdata", a_core_rdata, 32'h12345678);
            end
            if (c == 12) check("t4 ni_rdata kept", a_ni_rdata, 32'hCAFEF00D);
        end

        // 5: reset in the first WAIT cycle of a core read
        for (int c = 0; c <= 9; c++) begin
            cyc();
            if (c == 0) begin
                a_core_rd = 1'b1; a_core_addr = 32'h40; a_core_wdata = 32'h11111111;
            end
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            if (c == 9) a_core_rd = 1'b0;
            #1;
            check($sformatf("t5 mem_en c%0d", c), a_mem_en, (c == 1) || (c == 4));
            check($sformatf("t5 core_done c%0d", c), a_core_done, c == 8);
            if (c == 3) begin
                check("t5 mem_we", a_mem_we, 0);
                check("t5 mem_addr", a_mem_addr, 0);
                check("t5 mem_wdata", a_mem_wdata, 0);
                check("t5 core_rdata", a_core_rdata, 0);
                check("t5 ni_rdata", a_ni_rdata, 0);
                check("t5 ni_done", a_ni_done, 0);
            end
            if (c == 4) check("t5 reissue addr", a_mem_addr, 32'h40);
            if (c == 8) check("t5 core_rdata", a_core_rdata, 32'hDEADBEEF);
        end

        // 6: MEM_LAT=1 instance, core read dropped mid-access
        for (int c = 0; c <= 5; c++) begin
            cyc();
            if (c == 0) begin b_core_rd = 1'b1; b_core_addr = 32'h40; end
            if (c == 2) b_core_rd = 1'b0;
            #1;
            check($sformatf("t6 stall c%0d", c), b_core_stall, c <= 1);
            check($sformatf("t6 mem_en c%0d", c), b_mem_en, c == 1);
            check($sformatf("t6 core_done c%0d", c), b_core_done, c == 4);
            if (c == 3) check("t6 core_rdata", b_core_rdata, 32'h600DCAFE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
